// File: rtl/i2c_master_ctrl.sv
//======================================================================
// Module   : i2c_master_ctrl
// Brief    : Single-master I2C initiator (1/2-byte write/read) driving open-drain SCL/SDA enables.
// Revision : 1.0 - initial release
//======================================================================
`default_nettype none

module i2c_master_ctrl #(
  parameter int CLK_DIV = 250
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [6:0]  addr,
  input  logic [15:0] data_in,
  input  logic        two_bytes,
  input  logic        r_w,
  input  logic        load,
  output logic        busy,
  output logic        data_ready,
  output logic [15:0] rd_data,
  output logic        ack_err,
  output logic        scl_oe,
  output logic        sda_oe,
  input  logic        sda_i
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_START    = 4'd1,
    S_ADDR     = 4'd2,
    S_ADDR_ACK = 4'd3,
    S_WDATA    = 4'd4,
    S_WACK     = 4'd5,
    S_RDATA    = 4'd6,
    S_RACK     = 4'd7,
    S_STOP     = 4'd8
  } state_t;

  localparam logic [9:0] QMAX = 10'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [9:0]  qcnt_q, qcnt_d;
  logic [1:0]  quarter_q, quarter_d;
  logic [2:0]  bit_q, bit_d;
  logic        byte_q, byte_d;
  logic        ack_err_q, ack_err_d;
  logic [7:0]  addr_rw_q;
  logic [15:0] wdata_q;
  logic        two_q;
  logic        rw_q;
  logic [15:0] rx_q;
  logic        samp_q;
  logic        busy_q;
  logic        ready_q;
  logic [15:0] rd_data_q;
  logic        scl_oe_q, scl_oe_d;
  logic        sda_oe_q, sda_oe_d;
  logic        tick, sample, sym_end, start, rd_done, sym_scl;

  always_comb begin
    tick      = (qcnt_q == QMAX);
    sample    = tick && (quarter_q == 2'd2);
    sym_end   = tick && (quarter_q == 2'd3);
    start     = (state_q == S_IDLE) && load;
    rd_done   = 1'b0;
    state_d   = state_q;
    qcnt_d    = tick ? 10'd0 : qcnt_q + 10'd1;
    quarter_d = tick ? quarter_q + 2'd1 : quarter_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    ack_err_d = ack_err_q;
    if (state_q == S_IDLE) begin
      qcnt_d    = 10'd0;
      quarter_d = 2'd0;
      bit_d     = 3'd0;
      byte_d    = 1'b0;
      if (load) begin
        state_d   = S_START;
        ack_err_d = 1'b0;
      end
    end else if (sym_end) begin
      unique case (state_q)
        S_START: state_d = S_ADDR;
        S_ADDR: begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_ADDR_ACK;
        end
        S_ADDR_ACK: begin
          if (samp_q) begin
            ack_err_d = 1'b1;
            state_d   = S_STOP;
          end else begin
            state_d = rw_q ? S_RDATA : S_WDATA;
          end
        end
        S_WDATA: begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_WACK;
        end
        S_WACK: begin
          if (samp_q) begin
            ack_err_d = 1'b1;
            state_d   = S_STOP;
          end else if (two_q && !byte_q) begin
            byte_d  = 1'b1;
            state_d = S_WDATA;
          end else begin
            state_d = S_STOP;
          end
        end
        S_RDATA: begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_RACK;
        end
        S_RACK: begin
          if (two_q && !byte_q) begin
            byte_d  = 1'b1;
            state_d = S_RDATA;
          end else begin
            state_d = S_STOP;
          end
        end
        S_STOP: begin
          state_d = S_IDLE;
          rd_done = rw_q && !ack_err_q;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Pin enables are derived from the next state so the registered outputs line up with it.
  always_comb begin
    sym_scl  = (quarter_d == 2'd0) || (quarter_d == 2'd3);
    scl_oe_d = 1'b0;
    sda_oe_d = 1'b0;
    unique case (state_d)
      S_START: begin
        scl_oe_d = quarter_d[1];
        sda_oe_d = (quarter_d != 2'd0);
      end
      S_STOP: begin
        scl_oe_d = (quarter_d == 2'd0);
        sda_oe_d = !quarter_d[1];
      end
      S_ADDR: begin
        scl_oe_d = sym_scl;
        sda_oe_d = !addr_rw_q[~bit_d];
      end
      S_WDATA: begin
        scl_oe_d = sym_scl;
        sda_oe_d = !wdata_q[{~byte_d, ~bit_d}];
      end
      S_RACK: begin
        scl_oe_d = sym_scl;
        sda_oe_d = two_q && !byte_d;
      end
      S_ADDR_ACK, S_WACK, S_RDATA: scl_oe_d = sym_scl;
      default: begin
        scl_oe_d = 1'b0;
        sda_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      qcnt_q    <= 10'd0;
      quarter_q <= 2'd0;
      bit_q     <= 3'd0;
      byte_q    <= 1'b0;
      ack_err_q <= 1'b0;
      addr_rw_q <= 8'd0;
      wdata_q   <= 16'd0;
      two_q     <= 1'b0;
      rw_q      <= 1'b0;
      rx_q      <= 16'd0;
      samp_q    <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      rd_data_q <= 16'd0;
      scl_oe_q  <= 1'b0;
      sda_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      qcnt_q    <= qcnt_d;
      quarter_q <= quarter_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      ack_err_q <= ack_err_d;
      busy_q    <= (state_d != S_IDLE);
      ready_q   <= rd_done;
      scl_oe_q  <= scl_oe_d;
      sda_oe_q  <= sda_oe_d;
      if (rd_done) rd_data_q <= rx_q;
      if (sample) samp_q <= sda_i;
      if (start) begin
        addr_rw_q <= {addr, r_w};
        wdata_q   <= data_in;
        two_q     <= two_bytes;
        rw_q      <= r_w;
        rx_q      <= 16'd0;
      end else if (sample && (state_q == S_RDATA)) begin
        rx_q <= {rx_q[14:0], sda_i};
      end
    end
  end

  assign busy       = busy_q;
  assign data_ready = ready_q;
  assign rd_data    = rd_data_q;
  assign ack_err    = ack_err_q;
  assign scl_oe     = scl_oe_q;
  assign sda_oe     = sda_oe_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_master_ctrl.sv
//======================================================================
// Module   : tb_i2c_master_ctrl
// Brief    : Directed + random bench with an I2C slave/bus decoder for i2c_master_ctrl.
// Revision : 1.0 - initial release
//======================================================================
`default_nettype none

module tb_i2c_master_ctrl;

  localparam int CLK_DIV = 4;
  localparam int SYM     = 4 * CLK_DIV;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [6:0]  addr;
  logic [15:0] data_in;
  logic        two_bytes;
  logic        r_w;
  logic        load;
  logic        busy;
  logic        data_ready;
  logic [15:0] rd_data;
  logic        ack_err;
  logic        scl_oe;
  logic        sda_oe;
  logic        sda_i;

  always #5 clk = ~clk;

  i2c_master_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .addr       (addr),
    .data_in    (data_in),
    .two_bytes  (two_bytes),
    .r_w        (r_w),
    .load       (load),
    .busy       (busy),
    .data_ready (data_ready),
    .rd_data    (rd_data),
    .ack_err    (ack_err),
    .scl_oe     (scl_oe),
    .sda_oe     (sda_oe),
    .sda_i      (sda_i)
  );

  // Open-drain bus with a simple slave that ACKs/NACKs and serves read bytes.
  logic       slv_sda = 1'b1;
  logic       slv_nack = 1'b0;
  int         slv_nb = 1;
  logic [7:0] slv_rd [2];
  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  logic       in_xfer = 1'b0, addr_rd = 1'b0, addr_ack_ok = 1'b0;
  int         bitn = 0, byte_idx = 0, mon_starts = 0, mon_stops = 0;
  logic [8:0] frame = 9'd0;
  logic [8:0] frames [$];
  wire        scl_line = ~scl_oe;
  wire        sda_line = ~sda_oe & slv_sda;

  assign sda_i = sda_line;

  always @(negedge clk) begin
    prev_scl <= scl_line;
    prev_sda <= sda_line;
    if (!reset_n) begin
      in_xfer <= 1'b0;
      slv_sda <= 1'b1;
      bitn    <= 0;
    end else if (prev_scl && scl_line && prev_sda && !sda_line) begin
      in_xfer    <= 1'b1;
      bitn       <= 0;
      byte_idx   <= 0;
      frame      <= 9'd0;
      mon_starts <= mon_starts + 1;
    end else if (prev_scl && scl_line && !prev_sda && sda_line) begin
      mon_stops <= mon_stops + 1;
      in_xfer   <= 1'b0;
      slv_sda   <= 1'b1;
    end else if (in_xfer && !prev_scl && scl_line) begin
      if (bitn == 8) begin
        frames.push_back({frame[7:0], sda_line});
        if (byte_idx == 0) begin
          addr_rd     <= frame[0];
          addr_ack_ok <= !sda_line;
        end
        byte_idx <= byte_idx + 1;
        bitn     <= 0;
      end else begin
        frame <= {frame[7:0], sda_line};
        bitn  <= bitn + 1;
      end
    end else if (in_xfer && prev_scl && !scl_line) begin
      if (bitn == 8)
        slv_sda <= (byte_idx == 0) ? slv_nack : addr_rd;
      else if (addr_rd && addr_ack_ok && byte_idx >= 1 && byte_idx <= slv_nb)
        slv_sda <= slv_rd[byte_idx-1][7-bitn];
      else
        slv_sda <= 1'b1;
    end
  end

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_rd = 16'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input string tag, input logic [6:0] a, input logic [15:0] d,
                      input logic two, input logic rw, input logic nack,
                      input logic [7:0] rd0, input logic [7:0] rd1,
                      input int inj_at, input int abort_at);
    int nb, cnt, s0, p0, f0, dr_busy, exp_cnt;
    logic [8:0] ef [$];
    nb      = two ? 2 : 1;
    exp_cnt = SYM * (nack ? 11 : 2 + 9 * (1 + nb));
    ef.push_back({a, rw, nack});
    if (!nack)
      for (int i = 0; i < nb; i++)
        ef.push_back(rw ? {((i == 0) ? rd0 : rd1), (i == nb - 1)}
                        : {((i == 0) ? d[15:8] : d[7:0]), 1'b0});
    slv_nack  = nack;
    slv_nb    = nb;
    slv_rd[0] = rd0;
    slv_rd[1] = rd1;
    s0 = mon_starts;
    p0 = mon_stops;
    f0 = frames.size();

    @(negedge clk);
    addr = a; data_in = d; two_bytes = two; r_w = rw; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check($sformatf("%s.busy_rise", tag), 32'(busy), 32'd1);
    cnt = 0;
    dr_busy = 0;
    while (busy === 1'b1 && cnt < 4000) begin
      if (data_ready !== 1'b0) dr_busy++;
      if (cnt == inj_at) begin
        load = 1'b1; addr = ~a; data_in = ~d; two_bytes = ~two; r_w = ~rw;
      end else begin
        load = 1'b0;
      end
      if (cnt == abort_at) begin
        reset_n = 1'b0;
        break;
      end
      cnt++;
      @(negedge clk);
    end

    if (abort_at >= 0) begin
      @(negedge clk);
      check($sformatf("%s.busy", tag), 32'(busy), 32'd0);
      check($sformatf("%s.scl_oe", tag), 32'(scl_oe), 32'd0);
      check($sformatf("%s.sda_oe", tag), 32'(sda_oe), 32'd0);
      check($sformatf("%s.rd_data", tag), 32'(rd_data), 32'd0);
      exp_rd = 16'd0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      return;
    end

    check($sformatf("%s.busy_len", tag), 32'(cnt), 32'(exp_cnt));
    check($sformatf("%s.dr_in_busy", tag), 32'(dr_busy), 32'd0);
    check($sformatf("%s.data_ready", tag), 32'(data_ready), 32'(rw && !nack));
    if (rw && !nack) exp_rd = two ? {rd0, rd1} : {8'h00, rd0};
    check($sformatf("%s.rd_data", tag), 32'(rd_data), 32'(exp_rd));
    check($sformatf("%s.ack_err", tag), 32'(ack_err), 32'(nack));
    check($sformatf("%s.idle_pins", tag), 32'({scl_oe, sda_oe}), 32'd0);
    @(negedge clk);
    check($sformatf("%s.dr_pulse_end", tag), 32'(data_ready), 32'd0);
    check($sformatf("%s.starts", tag), 32'(mon_starts - s0), 32'd1);
    check($sformatf("%s.stops", tag), 32'(mon_stops - p0), 32'd1);
    check($sformatf("%s.nframes", tag), 32'(frames.size() - f0), 32'(ef.size()));
    for (int i = 0; i < ef.size(); i++)
      if (f0 + i < frames.size())
        check($sformatf("%s.frame%0d", tag, i), 32'(frames[f0+i]), 32'(ef[i]));
  endtask

  initial begin
    reset_n = 1'b0; load = 1'b0; addr = 7'd0; data_in = 16'd0; two_bytes = 1'b0; r_w = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.data_ready", 32'(data_ready), 32'd0);
    check("rst.rd_data", 32'(rd_data), 32'd0);
    check("rst.ack_err", 32'(ack_err), 32'd0);
    check("rst.scl_oe", 32'(scl_oe), 32'd0);
    check("rst.sda_oe", 32'(sda_oe), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    xfer("wr1",   7'h0D, 16'hA500, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, -1, -1);
    xfer("wr2",   7'h0D, 16'h3FFC, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, -1, -1);
    xfer("anack", 7'h0D, 16'h5A5A, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, -1, -1);
    xfer("rd2",   7'h48, 16'h0000, 1'b1, 1'b1, 1'b0, 8'h12, 8'h34, -1, -1);
    xfer("rd1",   7'h21, 16'h0000, 1'b0, 1'b1, 1'b0, 8'hC3, 8'h00, -1, -1);
    xfer("rdnack",7'h10, 16'h0000, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, -1, -1);
    xfer("abort", 7'h0D, 16'hA500, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, -1, 180);
    xfer("post",  7'h0D, 16'hA500, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, -1, -1);
    xfer("inj",   7'h55, 16'h9966, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 100, -1);

    for (int k = 0; k < 8; k++) begin
      xfer($sformatf("rnd%0d", k), 7'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 3) == 0), 8'($urandom), 8'($urandom), -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/i2c_master_ctrl.md
Name: i2c_master_ctrl

Overview:
- Single-master I2C initiator that executes the write/read requests issued by the DAC and trigger control FSMs.
- Sits between those request generators and the board I2C pins.
- Accepts a latched request (7-bit address, R/W, 1 or 2 data bytes) and drives open-drain SCL/SDA through output enables.
- Returns busy, read data with a data-ready pulse, and a NACK error flag.

Parameters:
- CLK_DIV, 250: clk cycles per quarter SCL period (100 MHz clk gives 100 kHz SCL); legal range 2..1023.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous reset, active low
- addr  in  7  target 7-bit slave address
- data_in  in  16  write data; [15:8] sent first, [7:0] sent second if two_bytes
- two_bytes  in  1  1 = transfer 2 data bytes, 0 = transfer 1 byte
- r_w  in  1  0 = write, 1 = read
- load  in  1  request strobe; sampled only in IDLE
- busy  out  1  transaction in progress
- data_ready  out  1  one-cycle pulse when a read has completed
- rd_data  out  16  read result
- ack_err  out  1  sticky NACK flag for the last transaction
- scl_oe  out  1  1 = pull SCL low; 0 = release
- sda_oe  out  1  1 = pull SDA low; 0 = release
- sda_i  in  1  sampled SDA pin level (pre-synchronised externally)

Behaviour:
- Reset (reset_n=0 at a clk edge): FSM returns to IDLE; all counters clear. Outputs: busy=0, data_ready=0, rd_data=0, ack_err=0, scl_oe=0, sda_oe=0. This applies mid-transaction too: the bus is released immediately and no STOP is generated.
- IDLE: load=1 latches addr, data_in, two_bytes, r_w; clears ack_err; busy=1 from the next cycle. A load while busy is ignored.
- Timing base: quarter counter of CLK_DIV cycles. A symbol is 4 quarters Q0..Q3.
- Data bit symbol:
  - Q0: SCL low, SDA set.
  - Q1, Q2: SCL released.
  - Q3: SCL low.
  - SDA is sampled on the last cycle of Q2.
- START symbol: Q0 both released; Q1 SDA low; Q2, Q3 SDA low and SCL low.
- STOP symbol: Q0 SCL low, SDA low; Q1 SCL released, SDA low; Q2, Q3 both released.
- States: IDLE -> START -> ADDR (8 bits: {addr, r_w}, MSB first) -> ADDR_ACK.
  - ADDR_ACK: master releases SDA; sda_i=1 means NACK. On NACK, set ack_err and go to STOP.
  - Write: WDATA (8 bits) -> WACK. NACK sets ack_err and goes to STOP. After ACK, go to the next byte if two_bytes and first byte, else STOP.
  - Read: RDATA (8 bits; SDA released, shift in sda_i MSB first) -> RACK.
    - RACK: master drives ACK (SDA low) if another byte follows, else NACK (released).
    - Then go to the next RDATA or to STOP.
  - STOP -> IDLE.
- Bit counter: 3 bits, wraps 7->0 on byte boundary. Byte counter: 1 bit.
- Transaction length: symbols = 2 + 9*(1+N), where N = two_bytes ? 2 : 1.
  - busy is high exactly symbols*4*CLK_DIV cycles, first high cycle the cycle after load.
  - If terminated early by an address NACK, symbols = 11.
- rd_data on read completion:
  - 2-byte read: {byte0, byte1}.
  - 1-byte read: {8'h00, byte0}.
  - rd_data updates on the same cycle as busy falls and holds until the next completed read.
  - A NACKed read does not update rd_data.
- data_ready: single-cycle pulse coincident with the first busy=0 cycle after a read that completed without an address NACK. Never pulses for writes.
- load asserted in the same cycle busy falls: accepted (FSM is IDLE that cycle only if busy already 0; otherwise ignored).
- scl_oe/sda_oe are registered outputs, glitch-free. No clock stretching; no arbitration.

Test Plan:
- Write 1 byte, CLK_DIV=4, addr=7'h0D, data_in=16'hA500, two_bytes=0, slave ACKs -> bus shows START, 0x1A, ACK, 0xA5, ACK, STOP; busy high 320 cycles; ack_err=0; no data_ready.
- Write 2 bytes, addr=7'h0D, data_in=16'h3FFC, two_bytes=1 -> bytes 0x1A, 0x3F, 0xFC; busy 464 cycles (CLK_DIV=4).
- Address NACK (sda_i held 1), write -> START, address, STOP after 11 symbols (176 cycles); ack_err=1; data bytes never driven.
- Read 2 bytes, addr=7'h48, slave returns 0x12, 0x34 -> address byte 0x91; master ACKs byte0, NACKs byte1; rd_data=16'h1234; data_ready pulses once.
- reset_n=0 during the 2nd data bit of a write -> next cycle busy=0, scl_oe=0, sda_oe=0; a subsequent load starts a clean START.
- load pulsed while busy (mid write) -> ignored; original transaction completes unchanged; busy falls at the expected cycle.
